// File: rtl/key_event_arbiter.sv
// key_event_arbiter: per-key short/long press classifier feeding a small event FIFO.
// Defining KEY_REPEAT_EN adds auto-repeat events while a key stays held.
//
// state     | meaning
// S_IDLE    | key released, waiting for key_rise
// S_PRESSED | key down, timing toward a long press
// S_HELD    | long press reported, waiting for key_fall (repeats if enabled)
module key_event_arbiter #(
  parameter int          N_KEYS     = 4,
  parameter int          KEY_W      = 2,
  parameter logic [26:0] LONG_CNT   = 27'd100_000_000,
  parameter logic [26:0] REPEAT_CNT = 27'd20_000_000,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_KEYS-1:0] key_rise,
  input  logic [N_KEYS-1:0] key_fall,
  output logic              evt_valid,
  input  logic              evt_ready,
  output logic [KEY_W-1:0]  evt_key,
  output logic [1:0]        evt_type,
  output logic              evt_overrun
);

  localparam int          PW          = $clog2(FIFO_DEPTH);
  localparam logic [26:0] LONG_LAST   = LONG_CNT - 27'd1;
  localparam logic [26:0] REPEAT_LAST = REPEAT_CNT - 27'd1;
  localparam logic [1:0]  T_SHORT     = 2'b00;
  localparam logic [1:0]  T_LONG      = 2'b01;
`ifdef KEY_REPEAT_EN
  localparam logic [1:0]  T_REPEAT    = 2'b10;
`endif

  typedef enum logic [1:0] {S_IDLE, S_PRESSED, S_HELD} key_state_e;

  key_state_e        state_q      [N_KEYS];
  key_state_e        state_d      [N_KEYS];
  logic [26:0]       timer_q      [N_KEYS];
  logic [26:0]       timer_d      [N_KEYS];
  logic [N_KEYS-1:0] tmr_hit;
  logic [N_KEYS-1:0] raise_q, raise_d;
  logic [1:0]        raise_type_q [N_KEYS];
  logic [1:0]        raise_type_d [N_KEYS];
  logic [N_KEYS-1:0] pend_vld_q, pend_vld_d;
  logic [1:0]        pend_type_q  [N_KEYS];
  logic [1:0]        pend_type_d  [N_KEYS];
  logic [N_KEYS-1:0] grant;
  logic              push, pop, full;
  logic              overrun_q, overrun_d;
  logic [KEY_W-1:0]  push_key;
  logic [1:0]        push_type;
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PW:0]       cnt_q, cnt_d;
  logic [KEY_W-1:0]  mem_key_q    [FIFO_DEPTH];
  logic [KEY_W-1:0]  mem_key_d    [FIFO_DEPTH];
  logic [1:0]        mem_type_q   [FIFO_DEPTH];
  logic [1:0]        mem_type_d   [FIFO_DEPTH];

  function automatic logic [26:0] sat_inc(input logic [26:0] v);
    return (v == '1) ? v : v + 27'd1;
  endfunction

  // One timer per key; the terminal count depends on whether the key is still pressed or held.
  always_comb begin
    for (int i = 0; i < N_KEYS; i++) begin
      tmr_hit[i] = (timer_q[i] == ((state_q[i] == S_HELD) ? REPEAT_LAST : LONG_LAST));
    end
  end

  always_comb begin
    for (int i = 0; i < N_KEYS; i++) begin
      state_d[i]      = state_q[i];
      timer_d[i]      = timer_q[i];
      raise_d[i]      = 1'b0;
      raise_type_d[i] = T_SHORT;
      unique case (state_q[i])
        S_IDLE: begin
          if (key_rise[i] && !key_fall[i]) begin
            state_d[i] = S_PRESSED;
            timer_d[i] = '0;
          end
        end
        S_PRESSED: begin
          if (key_fall[i]) begin
            state_d[i] = S_IDLE;
            raise_d[i] = 1'b1;
          end else if (tmr_hit[i]) begin
            state_d[i]      = S_HELD;
            timer_d[i]      = '0;
            raise_d[i]      = 1'b1;
            raise_type_d[i] = T_LONG;
          end else begin
            timer_d[i] = sat_inc(timer_q[i]);
          end
        end
        S_HELD: begin
          if (key_fall[i]) begin
            state_d[i] = S_IDLE;
`ifdef KEY_REPEAT_EN
          end else if (tmr_hit[i]) begin
            timer_d[i]      = '0;
            raise_d[i]      = 1'b1;
            raise_type_d[i] = T_REPEAT;
`endif
          end else begin
            timer_d[i] = sat_inc(timer_q[i]);
          end
        end
        default: state_d[i] = S_IDLE;
      endcase
    end
  end

  // Fixed priority: the lowest occupied pending slot wins the single push per cycle.
  always_comb begin
    pop       = evt_valid && evt_ready;
    full      = (cnt_q == (PW+1)'(FIFO_DEPTH));
    grant     = '0;
    push_key  = '0;
    push_type = T_SHORT;
    for (int i = N_KEYS - 1; i >= 0; i--) begin
      if (pend_vld_q[i]) begin
        grant     = '0;
        grant[i]  = 1'b1;
        push_key  = KEY_W'(i);
        push_type = pend_type_q[i];
      end
    end
    push      = (|pend_vld_q) && (!full || pop);
    overrun_d = overrun_q;
    for (int i = 0; i < N_KEYS; i++) begin
      pend_vld_d[i]  = pend_vld_q[i] && !(push && grant[i]);
      pend_type_d[i] = pend_type_q[i];
      if (raise_q[i]) begin
        if (pend_vld_d[i]) begin
          overrun_d = 1'b1;
        end else begin
          pend_vld_d[i]  = 1'b1;
          pend_type_d[i] = raise_type_q[i];
        end
      end
    end
  end

  always_comb begin
    mem_key_d  = mem_key_q;
    mem_type_d = mem_type_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    if (push) begin
      mem_key_d[wr_ptr_q]  = push_key;
      mem_type_d[wr_ptr_q] = push_type;
      wr_ptr_d             = wr_ptr_q + PW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    cnt_d = cnt_q + (PW+1)'(push) - (PW+1)'(pop);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N_KEYS; i++) begin
        state_q[i]      <= S_IDLE;
        timer_q[i]      <= '0;
        raise_type_q[i] <= T_SHORT;
        pend_type_q[i]  <= T_SHORT;
      end
      for (int j = 0; j < FIFO_DEPTH; j++) begin
        mem_key_q[j]  <= '0;
        mem_type_q[j] <= '0;
      end
      raise_q    <= '0;
      pend_vld_q <= '0;
      overrun_q  <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      raise_q      <= raise_d;
      raise_type_q <= raise_type_d;
      pend_vld_q   <= pend_vld_d;
      pend_type_q  <= pend_type_d;
      overrun_q    <= overrun_d;
      mem_key_q    <= mem_key_d;
      mem_type_q   <= mem_type_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      cnt_q        <= cnt_d;
    end
  end

  assign evt_valid   = (cnt_q != '0);
  assign evt_key     = mem_key_q[rd_ptr_q];
  assign evt_type    = mem_type_q[rd_ptr_q];
  assign evt_overrun = overrun_q;

endmodule

// File: tb/tb_key_event_arbiter.sv
// tb_key_event_arbiter: directed checks of press classification, arbitration order,
// backpressure/overrun, full-FIFO push+pop and reset, with LONG_CNT=20, REPEAT_CNT=8.
module tb_key_event_arbiter;

  localparam int LONG = 20;
  localparam int REP  = 8;
`ifdef KEY_REPEAT_EN
  localparam int HOLD_LONG = 40;
`else
  localparam int HOLD_LONG = 30;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] key_rise, key_fall;
  logic       evt_valid, evt_ready;
  logic [1:0] evt_key, evt_type;
  logic       evt_overrun;
  int         n_chk = 0;
  int         n_err = 0;

  always #5 clk = ~clk;

  key_event_arbiter #(
    .N_KEYS(4), .KEY_W(2), .LONG_CNT(27'd20), .REPEAT_CNT(27'd8), .FIFO_DEPTH(4)
  ) dut (
    .clk(clk), .rst(rst), .key_rise(key_rise), .key_fall(key_fall),
    .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_key(evt_key),
    .evt_type(evt_type), .evt_overrun(evt_overrun)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Drive for exactly one rising edge, starting and ending on a falling edge.
  task automatic pulse(input logic [3:0] rise_m, input logic [3:0] fall_m);
    key_rise = rise_m;
    key_fall = fall_m;
    @(negedge clk);
    key_rise = '0;
    key_fall = '0;
  endtask

  // Rise, fall 2 cycles later, then idle: one short event every 5 cycles.
  task automatic short_tap(input logic [3:0] m);
    pulse(m, 4'b0000);
    cycles(1);
    pulse(4'b0000, m);
    cycles(2);
  endtask

  // Press key for 'hold' cycles with evt_ready=1 and check every cycle for the expected event.
  task automatic press_scan(input int key, input int hold);
    logic [3:0] m;
    int exp_t;
    m = 4'b0001 << key;
    evt_ready = 1'b1;
    pulse(m, 4'b0000);
    for (int k = 1; k <= hold + 6; k++) begin
      @(negedge clk);
      exp_t = -1;
      if (hold <= LONG) begin
        if (k == hold + 2) exp_t = 0;
      end else begin
        if (k == LONG + 2) exp_t = 1;
`ifdef KEY_REPEAT_EN
        for (int t = LONG + REP; t < hold; t += REP) begin
          if (k == t + 2) exp_t = 2;
        end
`endif
      end
      chk($sformatf("press k%0d h%0d c%0d valid", key, hold, k), evt_valid, exp_t >= 0);
      if (exp_t >= 0) begin
        chk($sformatf("press k%0d h%0d c%0d key", key, hold, k), evt_key, key);
        chk($sformatf("press k%0d h%0d c%0d type", key, hold, k), evt_type, exp_t);
      end
      key_fall = (k == hold - 1) ? m : 4'b0000;
    end
    key_fall = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1);
  end

  initial begin
    int n_pop;
    logic seen;
    int exp_k[6];
    rst = 1'b1; key_rise = '0; key_fall = '0; evt_ready = 1'b0;
    cycles(2);
    rst = 1'b0;
    cycles(1);
    chk("rst valid", evt_valid, 0);
    chk("rst key", evt_key, 0);
    chk("rst type", evt_type, 0);
    chk("rst overrun", evt_overrun, 0);

    press_scan(1, 10);
    press_scan(2, HOLD_LONG);
    press_scan(3, LONG);
    press_scan(0, LONG + 1);
    cycles(2);

    // Keys 0, 2, 3 released together; expect ascending order on consecutive cycles.
    evt_ready = 1'b1;
    pulse(4'b1101, 4'b0000);
    cycles(3);
    pulse(4'b0000, 4'b1101);
    exp_k = '{-1, -1, 0, 2, 3, -1};
    for (int j = 0; j < 6; j++) begin
      if (j > 0) @(negedge clk);
      chk($sformatf("contend c%0d valid", j), evt_valid, exp_k[j] >= 0);
      if (exp_k[j] >= 0) begin
        chk($sformatf("contend c%0d key", j), evt_key, exp_k[j]);
        chk($sformatf("contend c%0d type", j), evt_type, 0);
      end
    end
    cycles(2);

    // Backpressure: 4 in FIFO, 1 pending, 6th lost.
    evt_ready = 1'b0;
    for (int p = 0; p < 6; p++) begin
      short_tap(4'b0001);
      if (p == 4) chk("bp overrun before 6th", evt_overrun, 0);
    end
    chk("bp overrun after 6th", evt_overrun, 1);
    chk("bp valid", evt_valid, 1);
    chk("bp head key", evt_key, 0);
    evt_ready = 1'b1;
    n_pop = 0;
    for (int j = 0; j < 10; j++) begin
      if (evt_valid) n_pop++;
      @(negedge clk);
    end
    chk("bp drain count", n_pop, 5);
    chk("bp overrun sticky", evt_overrun, 1);

    // Reset with 2 queued events and key 0 pressed.
    evt_ready = 1'b0;
    short_tap(4'b0010);
    short_tap(4'b0010);
    chk("pre-rst valid", evt_valid, 1);
    chk("pre-rst key", evt_key, 1);
    pulse(4'b0001, 4'b0000);
    cycles(2);
    rst = 1'b1;
    cycles(2);
    rst = 1'b0;
    cycles(1);
    chk("mid-rst valid", evt_valid, 0);
    chk("mid-rst key", evt_key, 0);
    chk("mid-rst type", evt_type, 0);
    chk("mid-rst overrun", evt_overrun, 0);
    pulse(4'b0000, 4'b0001);
    seen = 1'b0;
    for (int j = 0; j < 30; j++) begin
      seen = seen | evt_valid;
      @(negedge clk);
    end
    chk("no event after rst", seen, 0);

    // Full FIFO with key 1 pending: one pop must admit key 1 behind the remaining key-0 events.
    for (int p = 0; p < 4; p++) short_tap(4'b0001);
    short_tap(4'b0010);
    chk("full overrun", evt_overrun, 0);
    evt_ready = 1'b1;
    chk("full head valid", evt_valid, 1);
    chk("full head key", evt_key, 0);
    @(negedge clk);
    evt_ready = 1'b0;
    cycles(2);
    evt_ready = 1'b1;
    exp_k = '{0, 0, 0, 1, -1, -1};
    for (int j = 0; j < 6; j++) begin
      chk($sformatf("full drain %0d valid", j), evt_valid, exp_k[j] >= 0);
      if (exp_k[j] >= 0) begin
        chk($sformatf("full drain %0d key", j), evt_key, exp_k[j]);
        chk($sformatf("full drain %0d type", j), evt_type, 0);
      end
      @(negedge clk);
    end
    chk("full overrun after", evt_overrun, 0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
